// File: rtl/rom_mac_reader.sv
// ---------------------------------------------------------------------------
// rom_mac_reader
//
// Initiator for the dual-address product ROM. A start request launches a run
// over len address pairs (base_1+i, base_2+/-i). The ROM's product output is
// summed into a saturating accumulator for each pair.
//
// Build option:
//   ROM_MAC_READER_REVERSE_EN  defined     -> addr_2 steps downward (base_2-i)
//                              not defined -> addr_2 steps upward   (base_2+i)
//
// Ports:
//   clk       single clock
//   rst_n     synchronous active-low reset
//   start     run request, only honoured in IDLE
//   base_1    first address of stream 1 (latched on start)
//   base_2    first address of stream 2 (latched on start)
//   len       number of pairs, 0..2**ADDR_WIDTH (latched on start)
//   addr_1    registered address to ROM port 1
//   addr_2    registered address to ROM port 2
//   prod_in   ROM product for the current addr_1/addr_2
//   busy      high from start acceptance until done
//   done      one-cycle pulse, acc_out final while high
//   acc_out   registered saturating accumulator
//   overflow  sticky saturation flag, cleared on the next accepted start
// ---------------------------------------------------------------------------
module rom_mac_reader #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_1,
  input  logic [ADDR_WIDTH-1:0] base_2,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] addr_1,
  output logic [ADDR_WIDTH-1:0] addr_2,
  input  logic [DATA_WIDTH-1:0] prod_in,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_1_reg, addr_1_next;
  logic [ADDR_WIDTH-1:0] addr_2_reg, addr_2_next;
  logic [ADDR_WIDTH:0]   cnt_reg, cnt_next;
  logic [ADDR_WIDTH:0]   len_reg, len_next;
  logic [ACC_WIDTH-1:0]  acc_reg, acc_next;
  logic                  ovf_reg, ovf_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;

  // One extra bit catches the carry out of the accumulator add.
  logic [ACC_WIDTH:0]    acc_sum;
  logic [ADDR_WIDTH-1:0] addr_2_step;

  assign acc_sum = {1'b0, acc_reg} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, prod_in};

`ifdef ROM_MAC_READER_REVERSE_EN
  assign addr_2_step = addr_2_reg - ADDR_WIDTH'(1);
`else
  assign addr_2_step = addr_2_reg + ADDR_WIDTH'(1);
`endif

  always_comb begin
    state_next  = state_reg;
    addr_1_next = addr_1_reg;
    addr_2_next = addr_2_reg;
    cnt_next    = cnt_reg;
    len_next    = len_reg;
    acc_next    = acc_reg;
    ovf_next    = ovf_reg;
    busy_next   = busy_reg;
    done_next   = done_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          acc_next = '0;
          ovf_next = 1'b0;
          if (len != '0) begin
            len_next    = len;
            addr_1_next = base_1;
            addr_2_next = base_2;
            cnt_next    = (ADDR_WIDTH + 1)'(1);
            busy_next   = 1'b1;
            state_next  = RUN;
          end else begin
            // Empty run: no addresses are issued, go straight to the done pulse.
            done_next  = 1'b1;
            state_next = DONE;
          end
        end
      end

      RUN: begin
        // prod_in belongs to the addresses driven during this cycle.
        if (acc_sum[ACC_WIDTH]) begin
          acc_next = '1;
          ovf_next = 1'b1;
        end else begin
          acc_next = acc_sum[ACC_WIDTH-1:0];
        end

        if (cnt_reg < len_reg) begin
          addr_1_next = addr_1_reg + ADDR_WIDTH'(1);
          addr_2_next = addr_2_step;
          cnt_next    = cnt_reg + (ADDR_WIDTH + 1)'(1);
        end else begin
          // Last pair consumed; addresses hold their final values.
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = DONE;
        end
      end

      DONE: begin
        done_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        busy_next  = 1'b0;
        done_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_1_reg <= '0;
      addr_2_reg <= '0;
      cnt_reg    <= '0;
      len_reg    <= '0;
      acc_reg    <= '0;
      ovf_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_1_reg <= addr_1_next;
      addr_2_reg <= addr_2_next;
      cnt_reg    <= cnt_next;
      len_reg    <= len_next;
      acc_reg    <= acc_next;
      ovf_reg    <= ovf_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign addr_1   = addr_1_reg;
  assign addr_2   = addr_2_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign acc_out  = acc_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_rom_mac_reader.sv
// ---------------------------------------------------------------------------
// tb_rom_mac_reader
//
// Drives two instances (default ACC_WIDTH=16 and ACC_WIDTH=8) from the same
// stimulus. Each instance reads its own copy of the product ROM
// (rom[i] = i mod 16, product = rom[a1]*rom[a2] mod 16), optionally forced to
// 15. Expected addresses and sums come from a per-pair arithmetic model.
// ---------------------------------------------------------------------------
module tb_rom_mac_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] base_1, base_2;
  logic [6:0] len;
  bit         prod_force;

  logic [5:0]  addr_1a, addr_2a, addr_1b, addr_2b;
  logic [3:0]  prod_a, prod_b;
  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [15:0] acc_a;
  logic [7:0]  acc_b;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Model state that persists between runs.
  logic [5:0] exp_a1 = '0, exp_a2 = '0;
  int         last_s16 = 0, last_s8 = 0;
  bit         last_o16 = 0, last_o8 = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_prod(input logic [5:0] a1, input logic [5:0] a2);
    logic [7:0] p;
    p = a1[3:0] * a2[3:0];
    return p[3:0];
  endfunction

  assign prod_a = prod_force ? 4'd15 : rom_prod(addr_1a, addr_2a);
  assign prod_b = prod_force ? 4'd15 : rom_prod(addr_1b, addr_2b);

  rom_mac_reader #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .ACC_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_1(base_1), .base_2(base_2),
    .len(len), .addr_1(addr_1a), .addr_2(addr_2a), .prod_in(prod_a),
    .busy(busy_a), .done(done_a), .acc_out(acc_a), .overflow(ovf_a)
  );

  rom_mac_reader #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_1(base_1), .base_2(base_2),
    .len(len), .addr_1(addr_1b), .addr_2(addr_2b), .prod_in(prod_b),
    .busy(busy_b), .done(done_b), .acc_out(acc_b), .overflow(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp)
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy_a"}, busy_a, 0);
    check({tag, "_busy_b"}, busy_b, 0);
    check({tag, "_done_a"}, done_a, 0);
    check({tag, "_done_b"}, done_b, 0);
    check({tag, "_acc_a"}, acc_a, last_s16);
    check({tag, "_acc_b"}, acc_b, last_s8);
    check({tag, "_ovf_a"}, ovf_a, last_o16);
    check({tag, "_ovf_b"}, ovf_b, last_o8);
    check({tag, "_addr1"}, addr_1a, exp_a1);
    check({tag, "_addr2"}, addr_2b, exp_a2);
  endtask

  // One complete run. Entered and left on a falling edge.
  task automatic run(input logic [5:0] b1, input logic [5:0] b2, input logic [6:0] n,
                     input bit frc, input bit noisy);
    int         s16, s8, p;
    bit         o16, o8;
    logic [5:0] m1, m2;
    s16 = 0; s8 = 0; o16 = 0; o8 = 0;
    m1 = b1; m2 = b2;
    prod_force = frc;
    start = 1'b1; base_1 = b1; base_2 = b2; len = n;
    @(negedge clk);  // after E0
    start = 1'b0;
    if (noisy) begin
      base_1 = 6'($urandom); base_2 = 6'($urandom); len = 7'($urandom_range(0, 64));
    end
    check("e0_acc_a", acc_a, 0);
    check("e0_acc_b", acc_b, 0);
    check("e0_ovf_a", ovf_a, 0);
    check("e0_ovf_b", ovf_b, 0);
    if (n == 0) begin
      check("len0_busy", busy_a, 0);
      check("len0_done", done_a, 1);
      check("len0_done_b", done_b, 1);
      check("len0_addr1", addr_1a, exp_a1);
      check("len0_addr2", addr_2a, exp_a2);
    end else begin
      for (int k = 0; k < int'(n); k++) begin
        // Here the pair k is on the ROM address lines.
        check("run_busy_a", busy_a, 1);
        check("run_busy_b", busy_b, 1);
        check("run_done_a", done_a, 0);
        check("run_acc_a", acc_a, s16);
        check("run_acc_b", acc_b, s8);
        check("run_ovf_b", ovf_b, o8);
        check("run_addr1_a", addr_1a, m1);
        check("run_addr2_a", addr_2a, m2);
        check("run_addr1_b", addr_1b, m1);
        check("run_addr2_b", addr_2b, m2);
        p = frc ? 15 : int'(rom_prod(m1, m2));
        s16 += p; if (s16 > 65535) begin s16 = 65535; o16 = 1; end
        s8  += p; if (s8 > 255)    begin s8  = 255;   o8  = 1; end
        if (k < int'(n) - 1) begin
          m1 = m1 + 6'd1;
`ifdef ROM_MAC_READER_REVERSE_EN
          m2 = m2 - 6'd1;
`else
          m2 = m2 + 6'd1;
`endif
        end
        if (noisy) start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      // After E_N: done pulse, final sums, addresses holding the last pair.
      check("fin_done_a", done_a, 1);
      check("fin_done_b", done_b, 1);
      check("fin_busy_a", busy_a, 0);
      check("fin_acc_a", acc_a, s16);
      check("fin_acc_b", acc_b, s8);
      check("fin_ovf_a", ovf_a, o16);
      check("fin_ovf_b", ovf_b, o8);
      check("fin_addr1", addr_1a, m1);
      check("fin_addr2", addr_2a, m2);
      exp_a1 = m1; exp_a2 = m2;
    end
    last_s16 = s16; last_s8 = s8; last_o16 = o16; last_o8 = o8;
    $display("run b1=%0d b2=%0d len=%0d force=%0d -> acc16=%0d acc8=%0d ovf8=%0d",
             b1, b2, n, frc, s16, s8, o8);
    // DONE cycle: a start here must be ignored.
    if (noisy) start = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    check_idle("post");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_1 = '0; base_2 = '0; len = '0; prod_force = 0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed pairs from the plan.
    run(6'd2, 6'd3, 7'd3, 0, 0);
`ifdef ROM_MAC_READER_REVERSE_EN
    check("t1_acc_const", acc_a, 16);
`else
    check("t1_acc_const", acc_a, 22);
`endif
    run(6'd62, 6'd1, 7'd4, 0, 0);
    run(6'd7, 6'd9, 7'd0, 0, 0);
    run(6'd5, 6'd5, 7'd20, 1, 0);
    check("sat_acc8_const", acc_b, 255);
    repeat (3) begin
      @(negedge clk);
      check_idle("ovf_hold");
    end
    run(6'd0, 6'd63, 7'd64, 0, 0);

    // Abort a run with reset after an ignored extra start.
    prod_force = 0;
    start = 1'b1; base_1 = 6'd10; base_2 = 6'd20; len = 7'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_kept", busy_a, 1);
    check("abort_addr1", addr_1a, 6'd13);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_a1 = '0; exp_a2 = '0; last_s16 = 0; last_s8 = 0; last_o16 = 0; last_o8 = 0;
    check_idle("abort_rst");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_idle("abort_quiet");
    end

    // Randomized runs with noisy start/base/len while busy.
    for (int r = 0; r < 40; r++) begin
      logic [6:0] n;
      n = (r % 10 == 9) ? 7'd64 : 7'($urandom_range(0, 64));
      run(6'($urandom), 6'($urandom), n, ($urandom_range(0, 3) == 0), 1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_idle("gap");
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
